seek_f_decode: RTL and testbench
================================

Name: seek_f_decode

Overview:
- Inverse of the seek-value generator. It takes a packed seek word f = (s+m)*2^SHIFT - s - cc and recovers the quotient q = s+m and the residual r = s+cc.
- It flags words that no valid generator output could produce.
- It is a two-stage elastic pipeline with valid/ready on both sides, for the consumer side of the seek path.
- It keeps a saturating count of malformed words for debug.

Parameters:
- FW, 40, width of the input seek word f.
- SHIFT, 20, scale exponent used by the generator (2^SHIFT). Must satisfy 3 <= SHIFT < FW.
- RMAX, 4, largest legal residual (s<=1 plus cc<=3).
- CW, 8, width of the error counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- f, input, FW, seek word to decode.
- in_valid, input, 1, f is valid this cycle.
- in_ready, output, 1, block accepts f this cycle.
- q, output, FW-SHIFT+1, recovered quotient s+m.
- r, output, SHIFT, recovered residual s+cc.
- err, output, 1, r > RMAX (malformed word).
- out_valid, output, 1, q/r/err valid.
- out_ready, input, 1, downstream accepts this cycle.
- err_clr, input, 1, synchronous clear of err_cnt.
- err_cnt, output, CW, saturating count of err words delivered.

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. While reset=0:
  - s1_valid, out_valid and err_cnt are 0.
  - q, r, err and all stage registers are 0.
  - in_ready is 1 once reset is released.
- Transfers:
  - Input transfer = in_valid & in_ready on a clk edge.
  - Output transfer = out_valid & out_ready on a clk edge.
- Stage 1 (on input transfer):
  - Register f1 <= f.
  - Register r1 <= (2^SHIFT - f[SHIFT-1:0]) mod 2^SHIFT, i.e. the two's complement of the low SHIFT bits. f[SHIFT-1:0]=0 gives r1=0.
  - Set s1_valid.
- Stage 2 (on stage-1 advance):
  - q <= (f1 + r1) >> SHIFT, computed at FW+1 bits so the carry out of the top bit is kept.
  - r <= r1.
  - err <= (r1 > RMAX).
  - Set out_valid.
- Advance rules:
  - Stage 2 loads when s1_valid & (!out_valid | out_ready).
  - Stage 1 loads when in_valid & in_ready.
  - in_ready = !s1_valid | (!out_valid | out_ready). This is combinational and gives full throughput of 1 word/cycle.
  - When neither stage advances, its registers hold, so q/r/err stay stable while out_valid=1 and out_ready=0.
- s1_valid and out_valid clear only when their contents move on and nothing replaces them.
- Latency: accepted word appears on out_valid exactly 2 cycles later with no backpressure. Order is always preserved and no word is dropped or duplicated.
- Backpressure: if out_ready=0 with both stages full, in_ready=0 the same cycle. Accepted words stay buffered until drained.
- err_cnt:
  - Increments by 1 on each output transfer with err=1.
  - Saturates at 2^CW-1.
  - err_clr=1 forces 0 on the next edge. Clear has priority over a simultaneous increment.
- Ambiguity: r in {1,2,3} does not uniquely split into s and cc. The block reports r only; r=0 means s=cc=0, and r=4 means s=1, cc=3.
- Reset asserted mid-operation: in-flight words are discarded and all state returns to the reset values immediately (asynchronously).

Test Plan:
- f=5*2^20-3, in_valid for 1 cycle, out_ready=1 -> out_valid exactly 2 cycles after accept with q=5, r=3, err=0; err_cnt stays 0.
- f=0, then f=2^20 (back-to-back cycles) -> outputs on consecutive cycles: (q=0, r=0, err=0), then (q=1, r=0, err=0).
- f=3*2^20-10 -> q=3, r=10, err=1; err_cnt=1 after the output transfer. Then assert err_clr together with another err word -> err_cnt=0.
- Stream 4 words 7*2^20-1, 7*2^20-2, 7*2^20-3, 7*2^20-4 with out_ready=0 for cycles 2-5 -> in_ready drops after 2 words are held. When out_ready=1, all 4 words emerge in order with q=7 and r=1..4, and none are lost.
- Send 260 err words with out_ready=1 -> err_cnt reaches 255 and holds.
- Pulse reset low while both stages are full and out_ready=0 -> out_valid=0 and err_cnt=0 immediately. After release, in_ready=1 and the first new word comes out 2 cycles after it is accepted.

Source files
------------

// File: rtl/seek_f_decode.sv
// Seek-word decoder: recovers q = s+m and r = s+cc from f = q*2^SHIFT - r.
// Two-stage elastic valid/ready pipeline with a saturating malformed-word counter.
module seek_f_decode #(
  parameter int FW    = 40,
  parameter int SHIFT = 20,
  parameter int RMAX  = 4,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FW-1:0]       f,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [FW-SHIFT:0]   q,
  output logic [SHIFT-1:0]    r,
  output logic                err,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                err_clr,
  output logic [CW-1:0]       err_cnt
);

  localparam logic [SHIFT-1:0] RMAX_W  = SHIFT'(RMAX);
  localparam logic [CW-1:0]    CNT_MAX = '1;

  logic                  s1_valid_reg;
  logic [FW-1:0]         f1_reg;
  logic [SHIFT-1:0]      r1_reg;
  logic [FW-SHIFT:0]     q_reg;
  logic [SHIFT-1:0]      r_reg;
  logic                  err_reg;
  logic                  out_valid_reg;
  logic [CW-1:0]         err_cnt_reg;

  logic                  in_fire;
  logic                  out_fire;
  logic                  s2_load;
  logic [SHIFT-1:0]      r1_next;
  logic [FW:0]           sum_next;

  assign s2_load  = s1_valid_reg & (~out_valid_reg | out_ready);
  assign in_ready = ~s1_valid_reg | ~out_valid_reg | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_reg & out_ready;

  // Residual is the distance from f up to the next multiple of 2^SHIFT.
  assign r1_next  = {SHIFT{1'b0}} - f[SHIFT-1:0];
  // One extra bit so the carry out of f1 + r1 survives into q.
  assign sum_next = {1'b0, f1_reg} + {{(FW+1-SHIFT){1'b0}}, r1_reg};

  // Stage 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      f1_reg       <= '0;
      r1_reg       <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        f1_reg       <= f;
        r1_reg       <= r1_next;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Stage 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      r_reg         <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_reg <= 1'b1;
        q_reg         <= sum_next[FW:SHIFT];
        r_reg         <= r1_reg;
        err_reg       <= (r1_reg > RMAX_W);
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (out_fire && err_reg && (err_cnt_reg != CNT_MAX)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign q         = q_reg;
  assign r         = r_reg;
  assign err       = err_reg;
  assign out_valid = out_valid_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_seek_f_decode.sv
// Randomized and directed bench for seek_f_decode against a ceil-division
// reference model with an occupancy-based handshake model.
module tb_seek_f_decode;

  localparam int FW    = 40;
  localparam int SHIFT = 20;
  localparam int RMAX  = 4;
  localparam int CW    = 8;
  localparam longint unsigned SCALE = 64'd1 << SHIFT;

  logic              clk = 1'b0;
  logic              reset;
  logic [FW-1:0]     f;
  logic              in_valid;
  logic              in_ready;
  logic [FW-SHIFT:0] q;
  logic [SHIFT-1:0]  r;
  logic              err;
  logic              out_valid;
  logic              out_ready;
  logic              err_clr;
  logic [CW-1:0]     err_cnt;

  seek_f_decode #(.FW(FW), .SHIFT(SHIFT), .RMAX(RMAX), .CW(CW)) dut (
    .clk(clk), .reset(reset), .f(f), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .r(r), .err(err), .out_valid(out_valid), .out_ready(out_ready),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned q;
    longint unsigned r;
    bit              e;
    int              acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_cnt  = 0;
  bit   acc_last;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // q is f/2^SHIFT rounded up; r is the gap from f up to q*2^SHIFT.
  function automatic exp_t model(input longint unsigned fv, input int acc);
    exp_t e;
    e.q   = (fv + SCALE - 1) / SCALE;
    e.r   = e.q * SCALE - fv;
    e.e   = (e.r > RMAX);
    e.acc = acc;
    return e;
  endfunction

  task automatic step(input bit iv, input longint unsigned fv, input bit ordy, input bit clr);
    exp_t e;
    bit   want_ov;
    @(negedge clk);
    cyc++;
    in_valid = iv; f = fv[FW-1:0]; out_ready = ordy; err_clr = clr;
    #2;
    check("err_cnt", err_cnt, exp_cnt);
    check("in_ready", in_ready, (exp_q.size() < 2 || ordy) ? 1 : 0);
    want_ov = (exp_q.size() > 0) && (exp_q[0].acc + 2 <= cyc);
    check("out_valid", out_valid, want_ov);
    acc_last = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("q", q, e.q);
        check("r", r, e.r);
        check("err", err, e.e);
        $display("out cyc=%0d q=%0d r=%0d err=%0b err_cnt=%0d", cyc, q, r, err, err_cnt);
        if (!clr && e.e && exp_cnt < (1 << CW) - 1) exp_cnt++;
      end
    end
    if (clr) exp_cnt = 0;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(fv, cyc));
      acc_last = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  longint unsigned w[4];
  longint unsigned rf;
  int idx;

  initial begin
    reset = 1'b0; f = '0; in_valid = 0; out_ready = 1; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    @(negedge clk) reset = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // Single word, then back-to-back pair.
    step(1, 5 * SCALE - 3, 1, 0); idle(3);
    step(1, 0, 1, 0); step(1, SCALE, 1, 0); idle(3);

    // Error word, then clear coinciding with the next error-word transfer.
    step(1, 3 * SCALE - 10, 1, 0); idle(3);
    check("err_cnt_one", err_cnt, 1);
    step(1, 3 * SCALE - 10, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 1); idle(2);
    check("err_cnt_clr", err_cnt, 0);

    // Backpressure: four words with out_ready low for the first cycles.
    for (int i = 0; i < 4; i++) w[i] = 7 * SCALE - longint'(i + 1);
    idx = 0;
    for (int t = 0; t < 20; t++) begin
      step(idx < 4, w[idx < 4 ? idx : 0], t >= 4, 0);
      if (acc_last) idx++;
    end
    check("bp_all_accepted", idx, 4);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) step(1, 9 * SCALE - 100 - $urandom_range(0, 50), 1, 0);
    idle(3);
    check("err_cnt_sat", err_cnt, (1 << CW) - 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rf = {$urandom(), $urandom()} & ((64'd1 << FW) - 1);
      if ($urandom_range(0, 1) == 1) rf = (rf & ~(SCALE - 1)) - $urandom_range(0, 6);
      rf = rf & ((64'd1 << FW) - 1);
      step($urandom_range(0, 3) != 0, rf, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    end
    idle(4);

    // Fill both stages with error words under backpressure, then reset mid-flight.
    step(1, 3 * SCALE - 10, 1, 0); step(1, 3 * SCALE - 10, 1, 0); step(0, 0, 1, 0);
    step(1, 3 * SCALE - 10, 0, 0); step(1, 3 * SCALE - 10, 0, 0); step(0, 0, 0, 0);
    check("pre_rst_cnt_nz", err_cnt != 0, 1);
    @(negedge clk); #1 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_err", err, 0);
    exp_q.delete(); exp_cnt = 0;
    @(negedge clk) reset = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);
    step(1, 11 * SCALE - 4, 1, 0); idle(4);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
    check("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
